// File: rtl/pulse_train_gen_pkg.sv
// Shared encodings for the pulse-train generator and sibling timing blocks.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: out high for H cycles then low for L cycles,
// free-running or one-shot; lengths and mode are latched at each period start.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         mode,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  output logic         out,
  output logic         busy,
  output logic         done,
  output state_e       dbg_state
);

  localparam logic [W-1:0] ONE = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] lo_q, lo_d;
  logic         mode_q, mode_d;
  logic         out_q, out_d;
  logic         done_q, done_d;

  logic [W-1:0] hi_clamp;
  logic [W-1:0] lo_clamp;
  logic         start_cond;

  // A zero length would underflow the down-counter, so it is read as one.
  assign hi_clamp   = (high_len == '0) ? ONE : high_len;
  assign lo_clamp   = (low_len == '0) ? ONE : low_len;
  assign start_cond = (mode == MODE_FREE) ? en : start;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lo_q    <= '0;
      mode_q  <= MODE_FREE;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lo_d    = lo_q;
    mode_d  = mode_q;
    out_d   = out_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      out_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_d = 1'b0;
          if (start_cond) begin
            mode_d  = mode;
            lo_d    = lo_clamp;
            count_d = hi_clamp - ONE;
            out_d   = 1'b1;
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (count_q != '0) begin
            count_d = count_q - ONE;
          end else begin
            out_d   = 1'b0;
            count_d = lo_q - ONE;
            state_d = S_LOW;
          end
        end
        S_LOW: begin
          if (count_q != '0) begin
            count_d = count_q - ONE;
          end else begin
            done_d = 1'b1;
            // Free-running restart happens on the same edge: no idle gap.
            if (mode_q == MODE_FREE && en) begin
              mode_d  = mode;
              lo_d    = lo_clamp;
              count_d = hi_clamp - ONE;
              out_d   = 1'b1;
              state_d = S_HIGH;
            end else begin
              out_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          out_d   = 1'b0;
          count_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Parametrised pulse-train generator: drives `out` high for H clock cycles, then low for L cycles, either repeating (free-running) or as a single triggered period (one-shot). H and L are runtime inputs latched at the start of every period, with a counter width set by parameter. Used wherever the design needs programmable duty-cycle strobes or timed enables. With H=3, L=1 in free-running mode it produces the pattern 1,1,1,0.

## Interface
- `W`, default 4: counter and length width in bits. H and L range from 1 to 2^W−1.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = free-running, 1 = one-shot. Sampled only at period start.
- `en`  in  1  free-running enable. While 1 in mode 0, periods repeat back-to-back.
- `start`  in  1  one-shot trigger in mode 1. Ignored while `busy`.
- `stop`  in  1  synchronous abort. Takes priority over everything except reset.
- `high_len`  in  W  H, sampled at period start. 0 is treated as 1.
- `low_len`  in  W  L, sampled at period start. 0 is treated as 1.
- `out`  out  1  pulse output, registered.
- `busy`  out  1  1 while a period is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle strobe marking normal completion of a period.

## Operation
- **Internal registers:** state (IDLE, HIGH, LOW), COUNT[W−1:0], latched lo[W−1:0], latched mode, OUT, DONE.
- **Reset (`reset_` = 0, asynchronous):** state = IDLE, COUNT = 0, lo = 0, `out` = 0, `busy` = 0, `done` = 0. Reset held across clock edges keeps these values. Reset mid-period discards the period, and no `done` is produced.
- **Period start condition:** (mode = 0 and `en` = 1) or (mode = 1 and `start` = 1).
- **IDLE:** if the start condition holds:
  - latch mode and lo = max(`low_len`, 1);
  - COUNT ← max(`high_len`, 1) − 1;
  - OUT ← 1; state ← HIGH.
  - Otherwise hold with OUT = 0.
- **HIGH:**
  - COUNT ≠ 0 → COUNT ← COUNT − 1.
  - COUNT = 0 → OUT ← 0, COUNT ← lo − 1, state ← LOW.
- **LOW:**
  - COUNT ≠ 0 → decrement.
  - COUNT = 0 → DONE ← 1 for exactly one cycle. Then:
    - latched mode = 0 and `en` = 1: start a new period in the same edge (relatch lengths, OUT ← 1, state ← HIGH). There is no idle gap.
    - otherwise: state ← IDLE, OUT stays 0.
- **`en` falling mid-period:** the current period completes in full; there is no truncation.
- **`start` behaviour:**
  - `start` while `busy` = 1: ignored.
  - `start` held high in mode 1: a new period begins on the first IDLE edge, i.e. one idle cycle between periods.
- **`stop` = 1 at an edge:** state ← IDLE, OUT ← 0, DONE ← 0, COUNT ← 0. `stop` together with a start condition in IDLE: stays IDLE.
- **Input changes mid-period:** changes to `high_len`, `low_len` or `mode` have no effect until the next period start.
- **Arithmetic:** unsigned, W bits; COUNT never underflows because the length clamp guarantees a value of at least 1.

## Timing
- All outputs are registered and update after the rising edge of `clock`.
- `busy` is decoded from the state register only.
- **Latency:** start condition sampled at edge k → `out` = 1 from edge k to edge k+H, then 0 from edge k+H to edge k+H+L.
- **`done`:** high for the single cycle after edge k+H+L.
- **Free-running period:** exactly H+L cycles, with duty cycle H/(H+L).
- **One-shot back-to-back:** minimum spacing between periods is H+L+1 cycles.
- **Max lengths:** H = L = 2^W−1 gives a period of 2^(W+1)−2 cycles.

## Structure
- **Shared package:** state encoding constants S_IDLE, S_HIGH, S_LOW and mode constants MODE_FREE = 0, MODE_ONESHOT = 1, reused by sibling timing blocks.
- **Sub-modules:** none needed. One FSM plus one W-bit down-counter in a single module.

## Test plan
- **Reset:** assert `reset_` = 0 mid-HIGH with W = 4 → `out`, `busy`, `done` = 0 immediately (asynchronous); no `done` after release.
- **Free-running:** mode = 0, `en` = 1, H = 3, L = 1 → `out` sequence 1,1,1,0 repeating; `done` pulses every 4th cycle aligned with the return to 1.
- **One-shot:** mode = 1, single-cycle `start`, H = 2, L = 5 → `out` high 2 cycles, low 5 cycles, then `done` = 1 for 1 cycle; `busy` low afterwards. A second `start` during `busy` is ignored.
- **Zero clamp and maximum:** `high_len` = 0, `low_len` = 15 (W = 4) → H treated as 1: `out` high 1 cycle, low 15 cycles.
- **Abort:** `stop` pulsed during LOW with 3 cycles remaining → next edge IDLE, `out` = 0, no `done`. Then `en` = 1 restarts a fresh period.
- **Input change mid-period:** change `high_len` from 3 to 6 during HIGH in free-running mode → current period keeps H = 3; next period uses H = 6. Drop `en` mid-period → period completes, then IDLE.
